// File: rtl/rv32m_iter_div_pkg.sv
// Shared types for the RV32M iterative divider.
// Op encodings match funct3 of DIV/DIVU/REM/REMU.
package rv32m_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_DIV  = 3'b100,
    OP_DIVU = 3'b101,
    OP_REM  = 3'b110,
    OP_REMU = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  function automatic logic op_signed(logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/rv32m_iter_div_if.sv
// Request/result handshake bundle for the divider.
// The slave side is the divider, the master side is the pipeline.
interface rv32m_iter_div_if #(
  parameter int XLEN = rv32m_pkg::XLEN
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_x;
  logic [XLEN-1:0] i_y;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_res;

  modport master (
    output i_valid, i_op, i_x, i_y,
    output i_flush, i_ready,
    input  o_ready, o_valid, o_res
  );

  modport slave (
    input  i_valid, i_op, i_x, i_y,
    input  i_flush, i_ready,
    output o_ready, o_valid, o_res
  );
endinterface

// File: rtl/rv32m_iter_div_step.sv
// One restoring shift-subtract iteration.
// The compare is XLEN+1 wide so the shifted remainder never overflows.
module div_step #(
  parameter int XLEN = rv32m_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_dvd,
  input  logic [XLEN-1:0] i_dvsr,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_dvd,
  output logic            o_qbit
);
  logic [XLEN:0] w_sh;
  logic [XLEN:0] w_diff;

  // shift in next dividend bit, trial subtract, restore if negative
  always_comb begin
    w_sh   = {i_rem, i_dvd[XLEN-1]};
    w_diff = w_sh - {1'b0, i_dvsr};
    o_qbit = (w_sh >= {1'b0, i_dvsr});
    o_rem  = o_qbit ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
    o_dvd  = {i_dvd[XLEN-2:0], 1'b0};
  end
endmodule

// File: rtl/rv32m_iter_div.sv
// Iterative RV32M divider, one quotient bit per cycle.
// Zero divisor and signed overflow finish in one cycle.
module rv32m_iter_div
  import rv32m_pkg::*;
#(
  parameter  int XLEN  = rv32m_pkg::XLEN,
  localparam int CNT_W = $clog2(XLEN)
) (
  input logic             i_clk,
  input logic             i_rst_n,
  rv32m_iter_div_if.slave io_bus
);
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  div_state_e       r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem, r_dvd, r_dvsr, r_res;
  logic             r_qneg, r_rneg, r_isrem;

  logic             w_accept, w_sgn, w_xneg, w_yneg;
  logic             w_ill, w_dz, w_ovf, w_fast;
  logic [XLEN-1:0]  w_xabs, w_yabs, w_fast_res;
  logic [XLEN-1:0]  w_rem_nx, w_dvd_nx, w_q, w_final;
  logic             w_qbit;

  div_step #(.XLEN(XLEN)) u_step (
    .i_rem  (r_rem),
    .i_dvd  (r_dvd),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_nx),
    .o_dvd  (w_dvd_nx),
    .o_qbit (w_qbit)
  );

  // request decode: operand magnitudes and 1-cycle corner cases
  always_comb begin
    w_accept   = io_bus.i_valid && (r_state == IDLE) && !io_bus.i_flush;
    w_sgn      = op_signed(io_bus.i_op);
    w_xneg     = w_sgn & io_bus.i_x[XLEN-1];
    w_yneg     = w_sgn & io_bus.i_y[XLEN-1];
    w_xabs     = w_xneg ? -io_bus.i_x : io_bus.i_x;
    w_yabs     = w_yneg ? -io_bus.i_y : io_bus.i_y;
    w_ill      = !io_bus.i_op[2];
    w_dz       = io_bus.i_op[2] && (io_bus.i_y == '0);
    w_ovf      = w_sgn && (io_bus.i_x == MIN) && (io_bus.i_y == ONES);
    w_fast     = w_ill || w_dz || w_ovf;
    w_fast_res = '0;
    unique case (1'b1)
      w_ill:   w_fast_res = '0;
      w_dz:    w_fast_res = io_bus.i_op[1] ? io_bus.i_x : ONES;
      w_ovf:   w_fast_res = io_bus.i_op[1] ? '0 : io_bus.i_x;
      default: w_fast_res = '0;
    endcase
  end

  // final iteration result with sign fix-up
  always_comb begin
    w_q     = w_dvd_nx | XLEN'(w_qbit);
    w_final = r_isrem ? (r_rneg ? -w_rem_nx : w_rem_nx)
                      : (r_qneg ? -w_q : w_q);
  end

  // next-state logic, flush overrides everything
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_fast ? DONE : CALC;
      CALC:    if (r_cnt == '0) w_next = DONE;
      DONE:    if (io_bus.i_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (io_bus.i_flush) w_next = IDLE;
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // datapath registers: latch on accept, iterate in CALC
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvsr  <= '0;
      r_res   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_isrem <= 1'b0;
    end else if (io_bus.i_flush) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_isrem <= io_bus.i_op[1];
          r_qneg  <= w_xneg ^ w_yneg;
          r_rneg  <= w_xneg;
          r_dvd   <= w_xabs;
          r_dvsr  <= w_yabs;
          r_rem   <= '0;
          r_cnt   <= LAST;
          if (w_fast) r_res <= w_fast_res;
        end
        CALC: begin
          r_rem <= w_rem_nx;
          r_dvd <= w_q;
          r_cnt <= (r_cnt == '0) ? '0 : r_cnt - 1'b1;
          if (r_cnt == '0) r_res <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.o_ready = (r_state == IDLE);
  assign io_bus.o_valid = (r_state == DONE);
  assign io_bus.o_res   = r_res;
endmodule

// File: tb/tb_rv32m_iter_div.sv
// Directed bench for rv32m_iter_div.
// Expected results and latencies are hand-computed.
module tb_rv32m_iter_div;
  import rv32m_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;
  logic seen;
  logic [31:0] held;

  always #5 clk = ~clk;

  rv32m_iter_div_if #(.XLEN(32)) bus ();

  rv32m_iter_div #(.XLEN(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_x     = x;
    bus.i_y     = y;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_res(output int l);
    l = 1;
    while (!bus.o_valid && l < 100) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic take(input string tag);
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
    check({tag, " valid clr"}, 32'(bus.o_valid), 32'd0);
    check({tag, " ready set"}, 32'(bus.o_ready), 32'd1);
  endtask

  task automatic run(input string tag,
                     input logic [2:0] op,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input logic [31:0] exp,
                     input int exp_lat);
    int l;
    issue(op, x, y);
    wait_res(l);
    check({tag, " lat"}, 32'(l), 32'(exp_lat));
    check({tag, " res"}, bus.o_res, exp);
    take(tag);
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_op    = 3'b000;
    bus.i_x     = '0;
    bus.i_y     = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst ready", 32'(bus.o_ready), 32'd1);
    check("rst valid", 32'(bus.o_valid), 32'd0);
    check("rst res", bus.o_res, 32'd0);
    rst_n = 1'b1;

    run("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run("rem -7/2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run("divu /0", OP_DIVU, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1);
    run("remu /0", OP_REMU, 32'h12345678, 32'd0, 32'h12345678, 1);
    run("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run("divu min", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);
    run("div 100/-7", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
    run("non-div op", 3'b001, 32'd55, 32'd5, 32'd0, 1);

    issue(OP_DIVU, 32'd100, 32'd7);
    wait_res(lat);
    check("bp lat", 32'(lat), 32'd33);
    held = bus.o_res;
    check("bp res", held, 32'd14);
    bus.i_valid = 1'b1;
    bus.i_op    = OP_DIVU;
    bus.i_x     = 32'd1000;
    bus.i_y     = 32'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold res", bus.o_res, held);
      check("bp hold valid", 32'(bus.o_valid), 32'd1);
      check("bp hold ready", 32'(bus.o_ready), 32'd0);
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b0;
    check("bp done valid", 32'(bus.o_valid), 32'd0);
    check("bp done ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    check("bp no 2nd acc", 32'(bus.o_ready), 32'd1);

    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    check("fl in calc", 32'(bus.o_ready), 32'd0);
    bus.i_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_flush = 1'b0;
    check("fl ready", 32'(bus.o_ready), 32'd1);
    check("fl valid", 32'(bus.o_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1'b1;
    end
    check("fl no valid", 32'(seen), 32'd0);

    bus.i_valid = 1'b1;
    bus.i_op    = OP_DIVU;
    bus.i_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    check("fl blocks acc", 32'(bus.o_ready), 32'd1);

    run("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);

    issue(OP_REM, 32'd12345, 32'd77);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst ready", 32'(bus.o_ready), 32'd1);
    check("mrst valid", 32'(bus.o_valid), 32'd0);
    check("mrst res", bus.o_res, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1'b1;
    end
    check("mrst no valid", 32'(seen), 32'd0);

    run("rem -100/7", OP_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
